// File: rtl/cmp_pkg.sv
// Shared types for the compare scheduler: the result encoding, the FSM states and
// the fixed read latency of the block memory.
package cmp_pkg;

   localparam int unsigned MEM_RD_LATENCY = 2;

   typedef enum logic [1:0] {
      ResNone = 2'b00,
      ResLt   = 2'b01,
      ResGt   = 2'b10,
      ResEq   = 2'b11
   } result_e;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StIssue,
      StDrain,
      StRespond
   } state_e;

endpackage

// File: rtl/running_comparator.sv
// Folds block-wise compares (least significant block first) into a running magnitude
// result; a later, more significant, unequal block overrides the earlier verdict.
module running_comparator
   import cmp_pkg::*;
#(
   parameter int unsigned REGISTER_SIZE = 32,
   parameter int unsigned NUM_BLOCKS    = 128
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic                     blk_valid_in,
   input  logic [REGISTER_SIZE-1:0] blk_a_in,
   input  logic [REGISTER_SIZE-1:0] blk_b_in,
   output logic                     last_beat_out,
   output result_e                  result_out
);

   localparam int unsigned CNT_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

   logic [CNT_W-1:0] beat_q;
   result_e          result_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         beat_q   <= '0;
         result_q <= ResEq;
      end else if (blk_valid_in) begin
         beat_q <= beat_q + 1'b1;
         if (blk_a_in > blk_b_in) begin
            result_q <= ResGt;
         end else if (blk_a_in < blk_b_in) begin
            result_q <= ResLt;
         end
      end
   end

   assign last_beat_out = blk_valid_in && (beat_q == CNT_W'(NUM_BLOCKS - 1));
   assign result_out    = result_q;

endmodule

// File: rtl/compare_scheduler.sv
// Round-robin scheduler that streams two multi-block operands out of block memory
// through a running comparator and returns a single magnitude verdict per request.
module compare_scheduler
   import cmp_pkg::*;
#(
   parameter int unsigned REGISTER_SIZE = 32,
   parameter int unsigned NUM_BLOCKS    = 128,
   parameter int unsigned NUM_REQ       = 2,
   parameter int unsigned ADDR_W        = 10,
   localparam int unsigned ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                            clk_in,
   input  logic                            rst_n_in,
   input  logic [NUM_REQ-1:0]              req_valid_in,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr_a_in,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr_b_in,
   output logic [NUM_REQ-1:0]              req_ready_out,
   output logic                            mem_rd_en_out,
   output logic [ADDR_W-1:0]               mem_rd_addr_a_out,
   output logic [ADDR_W-1:0]               mem_rd_addr_b_out,
   input  logic [REGISTER_SIZE-1:0]        mem_rd_data_a_in,
   input  logic [REGISTER_SIZE-1:0]        mem_rd_data_b_in,
   output logic                            resp_valid_out,
   input  logic                            resp_ready_in,
   output logic [ID_W-1:0]                 resp_id_out,
   output logic [1:0]                      resp_result_out,
   output logic                            busy_out
);

   localparam int unsigned CNT_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

   state_e                    state_q;
   logic [ID_W-1:0]           ptr_q;
   logic [ID_W-1:0]           id_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [MEM_RD_LATENCY-1:0] vld_pipe_q;
   logic                      clear_q;
   logic                      rd_en_q;
   logic                      resp_valid_q;
   logic [ADDR_W-1:0]         addr_a_q;
   logic [ADDR_W-1:0]         addr_b_q;

   logic [NUM_REQ-1:0]        grant;
   logic [ID_W-1:0]           grant_idx;
   logic                      found;
   int unsigned               idx;
   logic                      cmp_rst_n;
   logic                      cmp_last_beat;
   result_e                   cmp_result;

   // Search starts at the pointer so the requester after the last winner goes first.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(ptr_q) + k) % NUM_REQ;
         if (!found && req_valid_in[ID_W'(idx)]) begin
            found                 = 1'b1;
            grant[ID_W'(idx)]     = 1'b1;
            grant_idx             = ID_W'(idx);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q      <= StIdle;
         ptr_q        <= '0;
         id_q         <= '0;
         cnt_q        <= '0;
         vld_pipe_q   <= '0;
         clear_q      <= 1'b0;
         rd_en_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         addr_a_q     <= '0;
         addr_b_q     <= '0;
      end else begin
         vld_pipe_q <= {vld_pipe_q[MEM_RD_LATENCY-2:0], rd_en_q};
         clear_q    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (grant != '0) begin
                  id_q     <= grant_idx;
                  ptr_q    <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                  addr_a_q <= req_addr_a_in[grant_idx];
                  addr_b_q <= req_addr_b_in[grant_idx];
                  clear_q  <= 1'b1;
                  state_q  <= StClear;
               end
            end
            StClear: begin
               cnt_q   <= '0;
               rd_en_q <= 1'b1;
               state_q <= StIssue;
            end
            StIssue: begin
               if (cnt_q == CNT_W'(NUM_BLOCKS - 1)) begin
                  rd_en_q <= 1'b0;
                  state_q <= StDrain;
               end else begin
                  cnt_q    <= cnt_q + 1'b1;
                  addr_a_q <= addr_a_q + 1'b1;
                  addr_b_q <= addr_b_q + 1'b1;
               end
            end
            StDrain: begin
               if (cmp_last_beat) begin
                  resp_valid_q <= 1'b1;
                  state_q      <= StRespond;
               end
            end
            StRespond: begin
               if (resp_ready_in) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // clear_q is a dedicated flop so the comparator reset cannot glitch on state decode.
   assign cmp_rst_n = rst_n_in & ~clear_q;

   running_comparator #(
      .REGISTER_SIZE (REGISTER_SIZE),
      .NUM_BLOCKS    (NUM_BLOCKS)
   ) u_running_comparator (
      .clk_in        (clk_in),
      .rst_n_in      (cmp_rst_n),
      .blk_valid_in  (vld_pipe_q[MEM_RD_LATENCY-1]),
      .blk_a_in      (mem_rd_data_a_in),
      .blk_b_in      (mem_rd_data_b_in),
      .last_beat_out (cmp_last_beat),
      .result_out    (cmp_result)
   );

   assign req_ready_out     = (state_q == StIdle && rst_n_in) ? grant : '0;
   assign mem_rd_en_out     = rd_en_q;
   assign mem_rd_addr_a_out = addr_a_q;
   assign mem_rd_addr_b_out = addr_b_q;
   assign resp_valid_out    = resp_valid_q;
   assign resp_id_out       = id_q;
   assign resp_result_out   = resp_valid_q ? cmp_result : ResNone;
   assign busy_out          = (state_q != StIdle);

endmodule

// File: tb/tb_compare_scheduler.sv
// Self-checking bench for compare_scheduler with 4 blocks of 8 bits and two requesters;
// a 2-cycle-latency memory model feeds operands, a queue holds expected responses.
module tb_compare_scheduler;

   localparam int unsigned RS = 8;
   localparam int unsigned NB = 4;
   localparam int unsigned NR = 2;
   localparam int unsigned AW = 10;

   logic                    clk_in = 1'b0;
   logic                    rst_n_in = 1'b0;
   logic [NR-1:0]           req_valid_in = '0;
   logic [NR-1:0][AW-1:0]   req_addr_a_in = '0;
   logic [NR-1:0][AW-1:0]   req_addr_b_in = '0;
   logic [NR-1:0]           req_ready_out;
   logic                    mem_rd_en_out;
   logic [AW-1:0]           mem_rd_addr_a_out;
   logic [AW-1:0]           mem_rd_addr_b_out;
   logic [RS-1:0]           mem_rd_data_a_in;
   logic [RS-1:0]           mem_rd_data_b_in;
   logic                    resp_valid_out;
   logic                    resp_ready_in = 1'b0;
   logic [0:0]              resp_id_out;
   logic [1:0]              resp_result_out;
   logic                    busy_out;

   compare_scheduler #(
      .REGISTER_SIZE (RS),
      .NUM_BLOCKS    (NB),
      .NUM_REQ       (NR),
      .ADDR_W        (AW)
   ) dut (
      .clk_in            (clk_in),
      .rst_n_in          (rst_n_in),
      .req_valid_in      (req_valid_in),
      .req_addr_a_in     (req_addr_a_in),
      .req_addr_b_in     (req_addr_b_in),
      .req_ready_out     (req_ready_out),
      .mem_rd_en_out     (mem_rd_en_out),
      .mem_rd_addr_a_out (mem_rd_addr_a_out),
      .mem_rd_addr_b_out (mem_rd_addr_b_out),
      .mem_rd_data_a_in  (mem_rd_data_a_in),
      .mem_rd_data_b_in  (mem_rd_data_b_in),
      .resp_valid_out    (resp_valid_out),
      .resp_ready_in     (resp_ready_in),
      .resp_id_out       (resp_id_out),
      .resp_result_out   (resp_result_out),
      .busy_out          (busy_out)
   );

   always #5 clk_in = ~clk_in;

   // Block memory with a fixed 2-cycle read latency.
   logic [RS-1:0] mem_a [1024];
   logic [RS-1:0] mem_b [1024];
   logic [RS-1:0] d1_a = '0, d2_a = '0, d1_b = '0, d2_b = '0;

   always @(posedge clk_in) begin
      d1_a <= mem_a[mem_rd_addr_a_out];
      d2_a <= d1_a;
      d1_b <= mem_b[mem_rd_addr_b_out];
      d2_b <= d1_b;
   end
   assign mem_rd_data_a_in = d2_a;
   assign mem_rd_data_b_in = d2_b;

   typedef struct {
      logic [NR-1:0] vmask;
      int unsigned   exp_id;
      logic [AW-1:0] addr_a;
      logic [AW-1:0] addr_b;
      logic [31:0]   a;
      logic [31:0]   b;
      logic [1:0]    exp_res;
      int unsigned   hold;
   } job_t;

   typedef struct {
      int unsigned id;
      logic [1:0]  res;
   } exp_t;

   exp_t exp_q[$];
   job_t jobs [7];
   job_t abort_job;
   job_t fresh_job;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({req_ready_out, mem_rd_en_out, mem_rd_addr_a_out, mem_rd_addr_b_out,
                  resp_valid_out, resp_id_out, resp_result_out, busy_out});
   endfunction

   // Granted slot carries the real base; the other slot a decoy, so a wrong latch shows.
   task automatic setup_job(input job_t j);
      for (int k = 0; k < int'(NB); k++) begin
         mem_a[AW'(32'(j.addr_a) + 32'(k))] = j.a[8*k +: 8];
         mem_b[AW'(32'(j.addr_b) + 32'(k))] = j.b[8*k +: 8];
      end
      for (int i = 0; i < int'(NR); i++) begin
         req_addr_a_in[i] = (i == int'(j.exp_id)) ? j.addr_a : (j.addr_a ^ 10'h2AA);
         req_addr_b_in[i] = (i == int'(j.exp_id)) ? j.addr_b : (j.addr_b ^ 10'h155);
      end
      req_valid_in = j.vmask;
   endtask

   task automatic run_job(input job_t j);
      exp_t        e;
      int unsigned w;
      int unsigned cyc;
      logic        seen;
      logic [3:0]  first;
      setup_job(j);
      #1;
      w = 0;
      while ((req_ready_out & j.vmask) == '0 && w < 20) begin
         @(negedge clk_in);
         #1;
         w++;
      end
      check("grant", 64'(req_ready_out), 64'(1) << j.exp_id);
      check("accept_wait", 64'(w), 64'(0));
      exp_q.push_back('{j.exp_id, j.exp_res});
      @(posedge clk_in);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk_in);
         cyc++;
         if (cyc <= NB + 3) begin
            check("rd_en", 64'(mem_rd_en_out), 64'(cyc >= 2 && cyc <= NB + 1));
            if (cyc >= 2 && cyc <= NB + 1) begin
               check("rd_addr_a", 64'(mem_rd_addr_a_out), 64'(AW'(32'(j.addr_a) + cyc - 2)));
               check("rd_addr_b", 64'(mem_rd_addr_b_out), 64'(AW'(32'(j.addr_b) + cyc - 2)));
            end
         end
         seen = resp_valid_out;
      end
      check("resp_latency", 64'(cyc), 64'(NB + 4));
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("resp_id", 64'(resp_id_out), 64'(e.id));
         check("resp_result", 64'(resp_result_out), 64'(e.res));
      end
      first = {resp_valid_out, resp_id_out, resp_result_out};
      for (int h = 0; h < int'(j.hold); h++) begin
         @(negedge clk_in);
         check("hold_stable", 64'({resp_valid_out, resp_id_out, resp_result_out}), 64'(first));
      end
      resp_ready_in = 1'b1;
      @(posedge clk_in);
      #1;
      resp_ready_in = 1'b0;
      req_valid_in  = '0;
      @(negedge clk_in);
      check("idle_after_hs", 64'({busy_out, resp_valid_out}), 64'(0));
   endtask

   // Ready must never show up while a job is in flight.
   always @(negedge clk_in) begin
      if (rst_n_in && busy_out) begin
         check("ready_outside_idle", 64'(req_ready_out), 64'(0));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

   initial begin
      logic seen_resp;
      //          vmask  id addr_a    addr_b    a             b             res    hold
      jobs[0] = '{2'b01, 0, 10'h010, 10'h020, 32'h04030201, 32'h05030201, 2'b01, 0};
      jobs[1] = '{2'b10, 1, 10'h030, 10'h040, 32'h090000FF, 32'h09000000, 2'b10, 0};
      jobs[2] = '{2'b11, 0, 10'h050, 10'h060, 32'h78563412, 32'h78563412, 2'b11, 0};
      jobs[3] = '{2'b11, 1, 10'h070, 10'h080, 32'h80000000, 32'h7FFFFFFF, 2'b10, 0};
      jobs[4] = '{2'b11, 0, 10'h090, 10'h0A0, 32'h00000009, 32'h01000001, 2'b01, 0};
      jobs[5] = '{2'b01, 0, 10'h0B0, 10'h0C0, 32'h40302010, 32'h40312010, 2'b01, 5};
      jobs[6] = '{2'b10, 1, 10'h3FE, 10'h200, 32'h02010101, 32'h01010101, 2'b10, 0};
      abort_job = '{2'b01, 0, 10'h100, 10'h110, 32'h11111111, 32'h11111111, 2'b11, 0};
      fresh_job = '{2'b11, 0, 10'h100, 10'h110, 32'h01000000, 32'h02000000, 2'b01, 0};

      // Requests pending during reset must not leak through ready.
      req_valid_in = 2'b11;
      repeat (3) @(negedge clk_in);
      check("reset_outputs", all_outs(), 64'(0));
      rst_n_in = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run_job(jobs[i]);
      end

      // Abort in DRAIN: in-flight beats must vanish and no response may appear.
      setup_job(abort_job);
      #1;
      check("abort_grant", 64'(req_ready_out), 64'(2'b01));
      @(posedge clk_in);
      repeat (NB + 2) @(negedge clk_in);
      check("abort_in_drain", 64'({busy_out, mem_rd_en_out}), 64'(2'b10));
      rst_n_in = 1'b0;
      #1;
      check("abort_reset_outputs", all_outs(), 64'(0));
      repeat (2) @(negedge clk_in);
      check("abort_reset_hold", all_outs(), 64'(0));
      rst_n_in     = 1'b1;
      req_valid_in = '0;
      seen_resp    = 1'b0;
      repeat (15) begin
         @(negedge clk_in);
         if (resp_valid_out) seen_resp = 1'b1;
      end
      check("no_resp_after_abort", 64'(seen_resp), 64'(0));

      run_job(fresh_job);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
